// File: rtl/controller_pkg.sv
// controller_pkg: shared types and encodings for the multi-cycle control unit.
//   - opcode localparams for every recognised RISC-V major opcode
//   - state_t: controller FSM states
//   - op_class_t: instruction classes produced by opcode_classifier
//   - ALUOp / RWSel encodings driven onto the datapath
package controller_pkg;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IMM  = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_HALT = 7'b0010111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEMORY,
      S_WRITEBACK,
      S_HALTED
   } state_t;

   // C_R is encoded as zero so the class register resets to a harmless value.
   typedef enum logic [3:0] {
      C_R,
      C_IMM,
      C_LW,
      C_SW,
      C_BR,
      C_LUI,
      C_JAL,
      C_JALR,
      C_HALT,
      C_ILLEGAL
   } op_class_t;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

   localparam logic [1:0] RWSEL_ALU = 2'b00;
   localparam logic [1:0] RWSEL_PC4 = 2'b01;
   localparam logic [1:0] RWSEL_LUI = 2'b10;

endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: combinational opcode -> instruction class lookup.
// Shared between the multi-cycle controller and the single-cycle decoder.
// Ports:
//   opcode_i    in  OPCODE_W  major opcode field of the instruction
//   op_class_o  out op_class_t  class of the opcode, C_ILLEGAL if unknown
module opcode_classifier
   import controller_pkg::*;
#(
   parameter int OPCODE_W = 7
) (
   input  logic [OPCODE_W-1:0] opcode_i,
   output op_class_t           op_class_o
);

   always_comb begin
      // NOTE: every path of a combinational block must assign its outputs;
      // the default first keeps synthesis from inferring a latch.
      op_class_o = C_ILLEGAL;
      case (opcode_i)
         OP_R:    op_class_o = C_R;
         OP_IMM:  op_class_o = C_IMM;
         OP_LW:   op_class_o = C_LW;
         OP_SW:   op_class_o = C_SW;
         OP_BR:   op_class_o = C_BR;
         OP_LUI:  op_class_o = C_LUI;
         OP_JAL:  op_class_o = C_JAL;
         OP_JALR: op_class_o = C_JALR;
         OP_HALT: op_class_o = C_HALT;
         default: op_class_o = C_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM sequencing each instruction through
// FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK against a shared memory with
// wait states, plus memory-wait timeout, HALT/resume, illegal-opcode trap and
// a retired-instruction counter.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   Opcode                opcode from the instruction register (used in DECODE)
//   mem_ready             memory handshake completion for the current request
//   resume                leave HALTED when no sticky error flag is set
//   mem_req, mem_we       memory request and write strobe
//   addr_src_pc           1: address = PC, 0: address = ALU result
//   ir_write, pc_write    IR/old-PC load and unconditional PC load
//   ALUSrc .. RWSel       datapath controls, as in the single-cycle decoder
//   halted, illegal, bus_error  status; the latter two are sticky
//   retired               completed-instruction count, wraps at 2^CNT_W
module multicycle_controller
   import controller_pkg::*;
#(
   parameter int OPCODE_W = 7,
   parameter int TIMEOUT  = 255,
   parameter int CNT_W    = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] Opcode,
   input  logic                mem_ready,
   input  logic                resume,
   output logic                mem_req,
   output logic                mem_we,
   output logic                addr_src_pc,
   output logic                ir_write,
   output logic                pc_write,
   output logic                ALUSrc,
   output logic                MemtoReg,
   output logic                RegWrite,
   output logic                Branch,
   output logic                JalrSel,
   output logic [1:0]          ALUOp,
   output logic [1:0]          RWSel,
   output logic                halted,
   output logic                illegal,
   output logic                bus_error,
   output logic [CNT_W-1:0]    retired
);

   localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   state_t            state_q;
   op_class_t         class_q;
   op_class_t         op_class;
   logic [WAIT_W-1:0] wait_q;
   logic              illegal_q;
   logic              bus_error_q;
   logic [CNT_W-1:0]  retired_q;
   logic              in_access;
   logic              timed_out;
   logic              retire;

   opcode_classifier #(.OPCODE_W(OPCODE_W)) u_classifier (
      .opcode_i   (Opcode),
      .op_class_o (op_class)
   );

   assign in_access = (state_q == S_FETCH) || (state_q == S_MEMORY);

   // The wait that would take the counter to TIMEOUT is the last one allowed;
   // a handshake in that same cycle still wins because mem_ready is checked first.
   assign timed_out = (TIMEOUT != 0) && in_access && !mem_ready &&
                      (wait_q == WAIT_W'(TIMEOUT - 1));

   assign retire = ((state_q == S_EXECUTE) && (class_q == C_BR)) ||
                   ((state_q == S_MEMORY) && (class_q == C_SW) && mem_ready) ||
                   (state_q == S_WRITEBACK);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         class_q     <= C_R;
         wait_q      <= '0;
         illegal_q   <= 1'b0;
         bus_error_q <= 1'b0;
         retired_q   <= '0;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every register
         // samples pre-edge values regardless of statement order.
         // The counter is zero whenever no wait is in progress, so it is
         // already cleared on every entry to FETCH or MEMORY.
         if (in_access && !mem_ready) wait_q <= wait_q + 1'b1;
         else                         wait_q <= '0;

         if (retire) retired_q <= retired_q + 1'b1;

         case (state_q)
            S_IDLE: state_q <= S_FETCH;
            S_FETCH: begin
               if (mem_ready) begin
                  state_q <= S_DECODE;
               end else if (timed_out) begin
                  bus_error_q <= 1'b1;
                  state_q     <= S_HALTED;
               end
            end
            S_DECODE: begin
               class_q <= op_class;
               case (op_class)
                  C_HALT: state_q <= S_HALTED;
                  C_ILLEGAL: begin
                     illegal_q <= 1'b1;
                     state_q   <= S_HALTED;
                  end
                  default: state_q <= S_EXECUTE;
               endcase
            end
            S_EXECUTE: begin
               case (class_q)
                  C_BR:       state_q <= S_FETCH;
                  C_LW, C_SW: state_q <= S_MEMORY;
                  default:    state_q <= S_WRITEBACK;
               endcase
            end
            S_MEMORY: begin
               if (mem_ready) begin
                  state_q <= (class_q == C_SW) ? S_FETCH : S_WRITEBACK;
               end else if (timed_out) begin
                  bus_error_q <= 1'b1;
                  state_q     <= S_HALTED;
               end
            end
            S_WRITEBACK: state_q <= S_FETCH;
            S_HALTED: begin
               if (resume && !illegal_q && !bus_error_q) state_q <= S_FETCH;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Controls decode only from the state and class registers; the fetch
   // strobes are additionally qualified by the handshake that completes them.
   always_comb begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      addr_src_pc = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      ALUSrc      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      Branch      = 1'b0;
      JalrSel     = 1'b0;
      ALUOp       = ALUOP_ADD;
      RWSel       = RWSEL_ALU;
      halted      = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req     = 1'b1;
            addr_src_pc = 1'b1;
            ir_write    = mem_ready;
            pc_write    = mem_ready;
         end
         S_EXECUTE: begin
            ALUSrc = class_q inside {C_LW, C_SW, C_IMM, C_JALR};
            // JAL sets both bits, giving ALUOp = 11.
            if (class_q inside {C_R, C_IMM, C_JAL, C_LUI}) ALUOp = ALUOp | ALUOP_FUNCT;
            if (class_q inside {C_BR, C_JAL})              ALUOp = ALUOp | ALUOP_BRANCH;
            Branch = (class_q == C_BR);
         end
         S_MEMORY: begin
            mem_req = 1'b1;
            mem_we  = (class_q == C_SW);
         end
         S_WRITEBACK: begin
            RegWrite = 1'b1;
            MemtoReg = (class_q == C_LW);
            if (class_q inside {C_JAL, C_JALR}) RWSel = RWSEL_PC4;
            else if (class_q == C_LUI)          RWSel = RWSEL_LUI;
            Branch   = (class_q == C_JAL);
            JalrSel  = (class_q == C_JALR);
            pc_write = (class_q == C_JALR);
         end
         S_HALTED: halted = 1'b1;
         default: ;
      endcase
   end

   assign illegal   = illegal_q;
   assign bus_error = bus_error_q;
   assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for multicycle_controller.
// A bench memory plays instruction programs (opcode plus per-access wait
// counts) through the handshake; expected retire/halt events are queued by
// the stimulus and compared by an independent monitor.
module tb_multicycle_controller;
   import controller_pkg::*;

   localparam int TIMEOUT = 4;
   localparam int NEVER   = 1000000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [6:0]  Opcode;
   logic        mem_ready;
   logic        resume = 1'b0;
   logic        mem_req, mem_we, addr_src_pc, ir_write, pc_write;
   logic        ALUSrc, MemtoReg, RegWrite, Branch, JalrSel;
   logic [1:0]  ALUOp, RWSel;
   logic        halted, illegal, bus_error;
   logic [31:0] retired;

   always #5 clk = ~clk;

   multicycle_controller #(.OPCODE_W(7), .TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready), .resume(resume),
      .mem_req(mem_req), .mem_we(mem_we), .addr_src_pc(addr_src_pc),
      .ir_write(ir_write), .pc_write(pc_write), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .Branch(Branch), .JalrSel(JalrSel), .ALUOp(ALUOp),
      .RWSel(RWSel), .halted(halted), .illegal(illegal), .bus_error(bus_error),
      .retired(retired)
   );

   typedef struct {
      logic [6:0] op;
      int         fw;   // wait cycles before the fetch handshake
      int         mw;   // wait cycles before the data handshake
      bit         scr;  // scramble Opcode after DECODE
   } instr_t;

   typedef struct {
      bit         is_halt;
      int         lat;
      int         ret;
      bit         rw;
      bit         m2r;
      logic [1:0] rws;
      logic [1:0] aop;
      bit         asrc;
      bit         ill;
      bit         berr;
   } exp_t;

   instr_t prog[$];
   exp_t   exp_q[$];
   int     pc = 0;
   int     n_tests = 0;
   int     n_fail = 0;
   int     ev_no = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic add(input logic [6:0] op, input int fw, input int mw, input bit scr);
      instr_t i;
      i.op = op; i.fw = fw; i.mw = mw; i.scr = scr;
      prog.push_back(i);
   endtask

   task automatic exp_ret(input int lat, input int ret, input bit rw, input bit m2r,
                          input logic [1:0] rws, input logic [1:0] aop, input bit asrc);
      exp_t e;
      e.is_halt = 1'b0; e.lat = lat; e.ret = ret; e.rw = rw; e.m2r = m2r;
      e.rws = rws; e.aop = aop; e.asrc = asrc; e.ill = 1'b0; e.berr = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic exp_halt(input int lat, input int ret, input bit ill, input bit berr);
      exp_t e;
      e.is_halt = 1'b1; e.lat = lat; e.ret = ret; e.rw = 1'b0; e.m2r = 1'b0;
      e.rws = 2'b00; e.aop = 2'b00; e.asrc = 1'b0; e.ill = ill; e.berr = berr;
      exp_q.push_back(e);
   endtask

   // Bench memory: presents instructions and answers handshakes after the
   // programmed number of wait cycles. Drives at posedge+1.
   initial begin : bench_memory
      bit     hs, rdy, dec, in_acc;
      int     left;
      instr_t cur;
      mem_ready = 1'b0;
      Opcode    = '0;
      dec = 1'b0; in_acc = 1'b0; left = 0;
      cur.op = '0; cur.fw = 0; cur.mw = 0; cur.scr = 1'b0;
      forever begin
         @(negedge clk);
         hs  = ir_write;
         rdy = mem_ready;
         @(posedge clk);
         #1;
         if (reset) begin
            in_acc = 1'b0; dec = 1'b0; mem_ready = 1'b0;
            continue;
         end
         if (dec && cur.scr) Opcode = 7'b1111111;
         dec = 1'b0;
         if (hs) begin
            if (pc < prog.size()) cur = prog[pc];
            pc++;
            Opcode = cur.op;
            dec    = 1'b1;
            in_acc = 1'b0;
         end else if (rdy) begin
            in_acc = 1'b0;
         end
         if (mem_req) begin
            if (!in_acc) begin
               in_acc = 1'b1;
               if (addr_src_pc) left = (pc < prog.size()) ? prog[pc].fw : NEVER;
               else             left = cur.mw;
            end
            if (left > 0) begin
               mem_ready = 1'b0;
               left--;
            end else begin
               mem_ready = 1'b1;
            end
         end else begin
            mem_ready = 1'b0;
            in_acc    = 1'b0;
         end
      end
   end

   // Monitor: detects retire (counter step) and halt (halted rising) events,
   // pops the scoreboard and compares latency, counter and controls.
   initial begin : monitor
      bit          f, p_fetch, p_halt, p_rw, p_m2r, ex_asrc;
      logic [1:0]  p_rws, ex_aop;
      logic [31:0] p_ret;
      int          sc, start, hs_sc;
      exp_t        e;
      sc = 0; start = 0; hs_sc = -10;
      p_fetch = 1'b0; p_halt = 1'b0; p_rw = 1'b0; p_m2r = 1'b0; p_rws = '0; p_ret = '0;
      ex_aop = '0; ex_asrc = 1'b0;
      forever begin
         @(negedge clk);
         sc++;
         if (reset) begin
            p_fetch = 1'b0; p_halt = 1'b0; p_ret = retired;
            continue;
         end
         f = mem_req && addr_src_pc;
         if (sc == hs_sc + 2) begin
            ex_aop  = ALUOp;
            ex_asrc = ALUSrc;
         end
         if ((retired !== p_ret) || (halted && !p_halt)) begin
            ev_no++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL ev%0d_unexpected: got retired=%0d halted=%0b, expected no event",
                        ev_no, retired, halted);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("ev%0d_is_halt", ev_no), halted, e.is_halt);
               check($sformatf("ev%0d_latency", ev_no), sc - start, e.lat);
               check($sformatf("ev%0d_retired", ev_no), retired, e.ret);
               if (e.is_halt) begin
                  check($sformatf("ev%0d_illegal", ev_no), illegal, e.ill);
                  check($sformatf("ev%0d_bus_error", ev_no), bus_error, e.berr);
               end else begin
                  check($sformatf("ev%0d_last_RegWrite", ev_no), p_rw, e.rw);
                  check($sformatf("ev%0d_last_MemtoReg", ev_no), p_m2r, e.m2r);
                  check($sformatf("ev%0d_last_RWSel", ev_no), p_rws, e.rws);
                  check($sformatf("ev%0d_exec_ALUOp", ev_no), ex_aop, e.aop);
                  check($sformatf("ev%0d_exec_ALUSrc", ev_no), ex_asrc, e.asrc);
               end
            end
         end
         if (f && !p_fetch) start = sc;
         if (ir_write) hs_sc = sc;
         p_fetch = f; p_halt = halted; p_ret = retired;
         p_rw = RegWrite; p_m2r = MemtoReg; p_rws = RWSel;
      end
   end

   task automatic apply_reset();
      @(posedge clk);
      #2;
      reset  = 1'b1;
      resume = 1'b0;
      @(posedge clk);
      #2;
      check("reset_ctrl", {mem_req, mem_we, addr_src_pc, ir_write, pc_write, ALUSrc, MemtoReg,
                           RegWrite, Branch, JalrSel, ALUOp, RWSel}, 0);
      check("reset_status", {halted, illegal, bus_error}, 0);
      check("reset_retired", retired, 0);
      prog.delete();
      exp_q.delete();
      pc = 0;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         check("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   initial begin : stimulus
      // Zero-wait mix, one instruction of each executing class.
      apply_reset();
      add(OP_R, 0, 0, 1'b1); add(OP_LW, 0, 0, 1'b0); add(OP_SW, 0, 0, 1'b0);
      add(OP_BR, 0, 0, 1'b0); add(OP_IMM, 0, 0, 1'b0); add(OP_LUI, 0, 0, 1'b0);
      add(OP_JAL, 0, 0, 1'b0); add(OP_JALR, 0, 0, 1'b0); add(OP_HALT, 0, 0, 1'b0);
      exp_ret(4, 1, 1, 0, 2'b00, 2'b10, 0);   // R
      exp_ret(5, 2, 1, 1, 2'b00, 2'b00, 1);   // LW
      exp_ret(4, 3, 0, 0, 2'b00, 2'b00, 1);   // SW
      exp_ret(3, 4, 0, 0, 2'b00, 2'b01, 0);   // BR
      exp_ret(4, 5, 1, 0, 2'b00, 2'b10, 1);   // I-imm
      exp_ret(4, 6, 1, 0, 2'b10, 2'b10, 0);   // LUI
      exp_ret(4, 7, 1, 0, 2'b01, 2'b11, 0);   // JAL
      exp_ret(4, 8, 1, 0, 2'b01, 2'b00, 1);   // JALR
      exp_halt(2, 8, 0, 0);
      reset = 1'b0;
      drain(200);

      // Wait states: 3 in MEMORY, then 3 in FETCH (handshake on the last allowed cycle).
      apply_reset();
      add(OP_LW, 0, 3, 1'b0); add(OP_R, 3, 0, 1'b0); add(OP_HALT, 0, 0, 1'b0);
      exp_ret(8, 1, 1, 1, 2'b00, 2'b00, 1);
      exp_ret(7, 2, 1, 0, 2'b00, 2'b10, 0);
      exp_halt(2, 2, 0, 0);
      reset = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (mem_req && !addr_src_pc) break;
      end
      check("mem_phase_seen", mem_req && !addr_src_pc, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mem_req_held", mem_req, 1);
      end
      drain(200);

      // Fetch never answered: timeout after 4 waits, resume ignored.
      apply_reset();
      add(OP_R, NEVER, 0, 1'b0);
      exp_halt(4, 0, 0, 1);
      reset = 1'b0;
      drain(100);
      #2;
      resume = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("timeout_resume_ignored", {halted, mem_req}, 2'b10);
      end
      resume = 1'b0;

      // Illegal opcode after one retired instruction; resume ignored.
      apply_reset();
      add(OP_R, 0, 0, 1'b0); add(7'b1111111, 0, 0, 1'b0);
      exp_ret(4, 1, 1, 0, 2'b00, 2'b10, 0);
      exp_halt(2, 1, 1, 0);
      reset = 1'b0;
      drain(100);
      #2;
      resume = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("illegal_resume_ignored", {halted, retired[7:0]}, {1'b1, 8'd1});
      end
      resume = 1'b0;

      // HALT then resume: fetch on the next edge, execution continues.
      apply_reset();
      add(OP_HALT, 0, 0, 1'b0); add(OP_R, 0, 0, 1'b0); add(OP_BR, 0, 0, 1'b0);
      add(OP_HALT, 0, 0, 1'b0);
      exp_halt(2, 0, 0, 0);
      exp_ret(4, 1, 1, 0, 2'b00, 2'b10, 0);
      exp_ret(3, 2, 0, 0, 2'b00, 2'b01, 0);
      exp_halt(2, 2, 0, 0);
      reset = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (halted) break;
      end
      check("halt_reached", halted, 1);
      @(posedge clk);
      #2;
      resume = 1'b1;
      @(posedge clk);
      #2;
      check("resume_to_fetch", mem_req && addr_src_pc, 1);
      resume = 1'b0;
      drain(200);

      // Reset in the middle of a waiting SW: strobes drop at once.
      apply_reset();
      add(OP_SW, 0, 3, 1'b0); add(OP_HALT, 0, 0, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (mem_we) break;
      end
      check("sw_strobe_seen", {mem_req, mem_we}, 2'b11);
      #1;
      reset = 1'b1;
      #1;
      check("async_drop", {mem_req, mem_we}, 2'b00);
      check("async_retired", retired, 0);
      prog.delete();
      exp_q.delete();
      pc = 0;
      add(OP_HALT, 0, 0, 1'b0);
      exp_halt(2, 0, 0, 0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("idle_after_release", {mem_req, addr_src_pc, halted}, 3'b000);
      @(posedge clk);
      #2;
      check("fetch_after_idle", mem_req && addr_src_pc, 1);
      drain(100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
